// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared encodings and constants for the instruction/data memory-port arbiter
package riscv_bus_pkg;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_I_ACC = 2'd1;
   localparam logic [1:0] ST_D_ACC = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;
   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      I_ACC = ST_I_ACC,
      D_ACC = ST_D_ACC,
      DONE  = ST_DONE
   } arbState_t;
   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;
   localparam logic [3:0] BE_WORD = 4'b1111;
   localparam logic [31:0] ZERO32 = 32'h0000_0000;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: two-way round-robin pick; bit 0 is the instruction side, bit 1 the data side
module arb_rr_pick
   import riscv_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);
   assign grant = (req == 2'b11) ? ((last == GRANT_I) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction and data buses
// with round-robin arbitration, stall generation and a watchdog that aborts hung accesses
module mem_port_arbiter
   import riscv_bus_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iIReadEnable,
   input  logic        iIWriteEnable,
   input  logic [3:0]  iIByteEnable,
   input  logic [31:0] iIAddress,
   input  logic [31:0] iIWriteData,
   output logic [31:0] oIReadData,
   output logic        oIReady,
   input  logic        iDReadEnable,
   input  logic        iDWriteEnable,
   input  logic [3:0]  iDByteEnable,
   input  logic [31:0] iDAddress,
   input  logic [31:0] iDWriteData,
   output logic [31:0] oDReadData,
   output logic        oDReady,
   output logic        oMReadEnable,
   output logic        oMWriteEnable,
   output logic [3:0]  oMByteEnable,
   output logic [31:0] oMAddress,
   output logic [31:0] oMWriteData,
   input  logic [31:0] iMReadData,
   input  logic        iMAck,
   output logic        oStall,
   output logic        oBusError
);
   arbState_t state;
   logic [1:0] req, grant;
   logic lastGrant, curSide, latRe, latWe, doneI, doneD;
   logic inAcc, timedOut, finish, setIReady, setDReady;
   logic [3:0] latBe;
   logic [31:0] latAddr, latWdata;
   logic [CNT_W-1:0] wdCnt;

   assign req = {iDReadEnable | iDWriteEnable, iIReadEnable | iIWriteEnable};
   assign inAcc = (state == I_ACC) || (state == D_ACC);
   assign timedOut = inAcc && !iMAck && (wdCnt == CNT_W'(TIMEOUT));
   assign finish = (inAcc && iMAck) || timedOut;
   // a requester that gave up mid-access gets no ready pulse
   assign setIReady = finish && (curSide == GRANT_I) && req[0];
   assign setDReady = finish && (curSide == GRANT_D) && req[1];

   assign oMReadEnable  = inAcc && latRe;
   assign oMWriteEnable = inAcc && latWe;
   assign oMByteEnable  = inAcc ? latBe : 4'b0000;
   assign oMAddress     = inAcc ? latAddr : ZERO32;
   assign oMWriteData   = inAcc ? latWdata : ZERO32;
   assign oStall = (|req) && !((!req[0] || doneI) && (!req[1] || doneD));

   arb_rr_pick uPick (.req(req), .last(lastGrant), .grant(grant));

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state      <= IDLE;
         lastGrant  <= GRANT_I;
         curSide    <= GRANT_I;
         latRe      <= 1'b0;
         latWe      <= 1'b0;
         latBe      <= BE_WORD;
         latAddr    <= ZERO32;
         latWdata   <= ZERO32;
         wdCnt      <= '0;
         oIReadData <= ZERO32;
         oDReadData <= ZERO32;
         oIReady    <= 1'b0;
         oDReady    <= 1'b0;
         oBusError  <= 1'b0;
         doneI      <= 1'b0;
         doneD      <= 1'b0;
      end else begin
         oIReady   <= setIReady;
         oDReady   <= setDReady;
         oBusError <= timedOut;
         doneI     <= req[0] && (doneI || setIReady);
         doneD     <= req[1] && (doneD || setDReady);
         case (state)
            IDLE: if (|req) begin
               curSide  <= grant[1];
               state    <= grant[1] ? D_ACC : I_ACC;
               latAddr  <= grant[1] ? iDAddress : iIAddress;
               latWdata <= grant[1] ? iDWriteData : iIWriteData;
               latBe    <= grant[1] ? iDByteEnable : iIByteEnable;
               latWe    <= grant[1] ? iDWriteEnable : iIWriteEnable;
               latRe    <= grant[1] ? (iDReadEnable & ~iDWriteEnable) : (iIReadEnable & ~iIWriteEnable);
               wdCnt    <= '0;
            end
            I_ACC, D_ACC: if (finish) begin
               state <= DONE;
               if ((curSide == GRANT_I) && (timedOut || !latWe))
                  oIReadData <= timedOut ? ZERO32 : iMReadData;
               if ((curSide == GRANT_D) && (timedOut || !latWe))
                  oDReadData <= timedOut ? ZERO32 : iMReadData;
            end else begin
               wdCnt <= wdCnt + 1'b1;
            end
            default: begin
               lastGrant <= curSide;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
   import riscv_bus_pkg::*;
   logic iCLK = 1'b0, iRST = 1'b1;
   logic iIReadEnable, iIWriteEnable, iDReadEnable, iDWriteEnable, iMAck;
   logic [3:0] iIByteEnable, iDByteEnable;
   logic [31:0] iIAddress, iIWriteData, iDAddress, iDWriteData, iMReadData;
   logic [31:0] oIReadData, oDReadData, oMAddress, oMWriteData;
   logic oIReady, oDReady, oMReadEnable, oMWriteEnable, oStall, oBusError;
   logic [3:0] oMByteEnable;
   int vectors = 0, errors = 0;

   localparam logic [31:0] IA = 32'h0040_0000;
   localparam logic [31:0] DA = 32'h1001_0004;

   mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .iIReadEnable(iIReadEnable), .iIWriteEnable(iIWriteEnable), .iIByteEnable(iIByteEnable),
      .iIAddress(iIAddress), .iIWriteData(iIWriteData), .oIReadData(oIReadData), .oIReady(oIReady),
      .iDReadEnable(iDReadEnable), .iDWriteEnable(iDWriteEnable), .iDByteEnable(iDByteEnable),
      .iDAddress(iDAddress), .iDWriteData(iDWriteData), .oDReadData(oDReadData), .oDReady(oDReady),
      .oMReadEnable(oMReadEnable), .oMWriteEnable(oMWriteEnable), .oMByteEnable(oMByteEnable),
      .oMAddress(oMAddress), .oMWriteData(oMWriteData), .iMReadData(iMReadData), .iMAck(iMAck),
      .oStall(oStall), .oBusError(oBusError)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic waitAct(input string tag, input int bound);
      for (int k = 0; k < bound && !(oMReadEnable | oMWriteEnable); k++) step();
      chk(tag, 32'(oMReadEnable | oMWriteEnable), 32'd1);
   endtask

   function automatic logic [31:0] memFn(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // both requesting: the side not served last; otherwise whoever asks
   function automatic int pick(input bit ri, input bit rd, input int last);
      if (ri && rd) return (last == 0) ? 1 : 0;
      return rd ? 1 : 0;
   endfunction

   bit act[2];
   logic re[2], we[2];
   logic [3:0] be[2];
   logic [31:0] addr[2], wdata[2], expRd[2];

   task automatic drive();
      iIReadEnable = act[0] && re[0]; iIWriteEnable = act[0] && we[0];
      iDReadEnable = act[1] && re[1]; iDWriteEnable = act[1] && we[1];
      iIByteEnable = be[0]; iDByteEnable = be[1];
      iIAddress = addr[0]; iDAddress = addr[1];
      iIWriteData = wdata[0]; iDWriteData = wdata[1];
   endtask

   task automatic newReq(input int s);
      int kind;
      kind = $urandom_range(0, 2);
      re[s] = (kind != 1);
      we[s] = (kind != 0);
      be[s] = 4'($urandom);
      addr[s] = (s == 1 ? 32'h1001_0000 : 32'h0040_0000) | ($urandom & 32'h0000_FFFC);
      wdata[s] = $urandom;
      act[s] = 1'b1;
   endtask

   initial begin
      int n, side, mLast, delay, wc;
      bit portAct, prevAct, ackPrev, ackNow, expNextAct, inDone, rI, rD;
      logic [31:0] t5Data;
      iIReadEnable = 0; iIWriteEnable = 0; iDReadEnable = 0; iDWriteEnable = 0; iMAck = 0;
      iIByteEnable = BE_WORD; iDByteEnable = BE_WORD; iIAddress = 0; iDAddress = 0;
      iIWriteData = 0; iDWriteData = 0; iMReadData = 0;
      repeat (2) @(posedge iCLK);
      #1 iRST = 1'b0;
      chk("rst_port", {oMReadEnable, oMWriteEnable, oMByteEnable}, 32'd0);
      chk("rst_addr", oMAddress, 32'd0);
      chk("rst_pulses", {oIReady, oDReady, oBusError, oStall}, 32'd0);
      chk("rst_rdata", oIReadData | oDReadData, 32'd0);

      // single instruction read
      iIReadEnable = 1; iIAddress = IA;
      #1 chk("t1_stall_req", oStall, 1);
      step();
      chk("t1_addr", oMAddress, IA);
      chk("t1_re", {oMReadEnable, oMWriteEnable, oIReady}, 32'b100);
      iMAck = 1; iMReadData = 32'h0000_0013;
      step();
      chk("t1_addr_gone", oMAddress, 0);
      chk("t1_ready", oIReady, 1);
      chk("t1_rdata", oIReadData, 32'h13);
      chk("t1_stall", oStall, 0);
      iIReadEnable = 0; iMAck = 0;
      step();
      chk("t1_ready_once", oIReady, 0);

      // simultaneous I read and D write; last grant was I so D goes first
      iIReadEnable = 1; iIAddress = IA;
      iDWriteEnable = 1; iDAddress = DA; iDWriteData = 32'hDEAD_BEEF; iDByteEnable = 4'b0011;
      step();
      chk("t2_daddr", oMAddress, DA);
      chk("t2_dctl", {oMWriteEnable, oMReadEnable, oMByteEnable}, 32'b10_0011);
      chk("t2_dwdata", oMWriteData, 32'hDEAD_BEEF);
      iMAck = 1; iMReadData = 32'hBAD0_BAD0;
      step();
      chk("t2_dready", {oDReady, oIReady}, 32'b10);
      chk("t2_stall_mid", oStall, 1);
      chk("t2_dwrite_rdata", oDReadData, 0);
      iDWriteEnable = 0; iMAck = 0;
      step();
      chk("t2_idle_stall", {oStall, oMReadEnable}, 32'b10);
      step();
      chk("t2_iaddr", oMAddress, IA);
      iMAck = 1; iMReadData = 32'h0000_0077;
      step();
      chk("t2_iready", oIReady, 1);
      chk("t2_stall_end", oStall, 0);
      chk("t2_irdata", oIReadData, 32'h77);
      iIReadEnable = 0; iMAck = 0;

      // continuous requests from both sides alternate D, I, D, I ...
      iIReadEnable = 1; iDReadEnable = 1; iDAddress = DA;
      for (int g = 0; g < 10; g++) begin
         waitAct("t3_grant", 4);
         chk("t3_side", oMAddress, (g % 2 == 0) ? DA : IA);
         iMAck = 1; iMReadData = memFn(oMAddress);
         step();
         chk("t3_ready", {oDReady, oIReady}, (g % 2 == 0) ? 32'b10 : 32'b01);
         iMAck = 0;
      end
      iIReadEnable = 0; iDReadEnable = 0;
      step();

      // watchdog abort on a D read
      iDReadEnable = 1; iDAddress = 32'h1001_0010;
      step();
      chk("t4_grant", {oMReadEnable, oMAddress}, 32'h1001_0010);
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (oDReady) begin n = k; break; end
      end
      chk("t4_cycles", n, 17);
      chk("t4_berr", oBusError, 1);
      chk("t4_rdata", oDReadData, 0);
      iDReadEnable = 0;
      step();
      chk("t4_idle", {oBusError, oDReady, oMReadEnable}, 0);

      // reset while a D read is waiting
      iDReadEnable = 1; iDAddress = DA;
      step();
      step();
      iRST = 1;
      #1;
      chk("t5_port", {oMReadEnable, oMWriteEnable, oMByteEnable}, 0);
      chk("t5_addr", oMAddress, 0);
      chk("t5_pulses", {oDReady, oBusError}, 0);
      #2 iRST = 0;
      waitAct("t5_regrant", 3);
      chk("t5_addr2", oMAddress, DA);
      t5Data = 32'h5555_1234;
      iMAck = 1; iMReadData = t5Data;
      step();
      chk("t5_ready", {oDReady, oBusError}, 32'b10);
      chk("t5_rdata", oDReadData, t5Data);
      iDReadEnable = 0; iMAck = 0;
      step();

      // I write with both enables: treated as a write
      iIReadEnable = 1; iIWriteEnable = 1; iIAddress = 32'h0000_0100;
      iIWriteData = 32'h1234_5678; iIByteEnable = BE_WORD;
      step();
      chk("t6_ctl", {oMWriteEnable, oMReadEnable, oMByteEnable}, 32'b10_1111);
      chk("t6_wdata", oMWriteData, 32'h1234_5678);
      iMAck = 1; iMReadData = 32'hFFFF_0000;
      step();
      chk("t6_ready", oIReady, 1);
      chk("t6_rdata_kept", oIReadData, 0);
      iIReadEnable = 0; iIWriteEnable = 0; iMAck = 0;
      step();

      // request dropped mid-access
      iIReadEnable = 1; iIAddress = 32'h0040_0008;
      step();
      iIReadEnable = 0; iMAck = 1; iMReadData = 32'hCAFE_F00D;
      step();
      chk("t7_no_ready", {oIReady, oBusError}, 0);
      chk("t7_rdata", oIReadData, 32'hCAFE_F00D);
      iMAck = 0;
      step();

      // randomized traffic
      for (int s = 0; s < 2; s++) begin
         act[s] = 0; re[s] = 0; we[s] = 0; be[s] = 0; addr[s] = 0; wdata[s] = 0;
      end
      expRd[0] = 32'hCAFE_F00D; expRd[1] = t5Data;
      mLast = 0; side = 0; prevAct = 0; ackPrev = 0; expNextAct = 0; delay = 0; wc = 0;
      drive();
      for (int c = 0; c < 400; c++) begin
         step();
         portAct = oMReadEnable | oMWriteEnable;
         chk("rnd_active", portAct, expNextAct);
         if (portAct && !prevAct) begin
            side = pick(act[0], act[1], mLast);
            chk("rnd_addr", oMAddress, addr[side]);
            chk("rnd_ctl", {oMWriteEnable, oMReadEnable, oMByteEnable}, {we[side], re[side] & ~we[side], be[side]});
            chk("rnd_wdata", oMWriteData, wdata[side]);
         end
         if (ackPrev) begin
            if (!we[side]) expRd[side] = memFn(addr[side]);
            mLast = side;
         end
         rI = ackPrev && side == 0;
         rD = ackPrev && side == 1;
         chk("rnd_ready", {oDReady, oIReady, oBusError}, {rD, rI, 1'b0});
         chk("rnd_irdata", oIReadData, expRd[0]);
         chk("rnd_drdata", oDReadData, expRd[1]);
         chk("rnd_stall", oStall, (act[0] || act[1]) && !((!act[0] || rI) && (!act[1] || rD)));
         inDone = ackPrev;
         ackNow = 0;
         if (portAct) begin
            if (!prevAct) begin delay = $urandom_range(0, 3); wc = 0; end
            ackNow = (wc == delay);
            wc++;
         end
         iMAck = portAct ? ackNow : 1'($urandom_range(0, 1));
         iMReadData = (portAct && ackNow) ? memFn(oMAddress) : $urandom;
         if (rI) act[0] = 0; else if (!act[0] && $urandom_range(0, 2) == 0) newReq(0);
         if (rD) act[1] = 0; else if (!act[1] && $urandom_range(0, 2) == 0) newReq(1);
         drive();
         expNextAct = portAct ? !ackNow : (!inDone && (act[0] || act[1]));
         ackPrev = portAct && ackNow;
         prevAct = portAct;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
